// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU, iterative MUL and an optional
// restoring DIVU that is compiled in only when EX_DIV_EN is defined.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IdEx_Jump,
    input  logic             IdEx_Branch,
    input  logic             IdEx_MemRead,
    input  logic             IdEx_MemtoReg,
    input  logic             IdEx_MemWrite,
    input  logic             IdEx_RegWrite,
    input  logic [3:0]       IdEx_AluCtrl,
    input  logic             IdEx_AluSrc,
    input  logic [WIDTH-1:0] IdEx_DataRs,
    input  logic [WIDTH-1:0] IdEx_DataRt,
    input  logic [WIDTH-1:0] IdEx_Imm,
    input  logic [4:0]       IdEx_AddrRdRt,
    output logic             ExMem_Jump,
    output logic             ExMem_Branch,
    output logic             ExMem_MemRead,
    output logic             ExMem_MemtoReg,
    output logic             ExMem_MemWrite,
    output logic             ExMem_RegWrite,
    output logic [WIDTH-1:0] ExMem_AluOut,
    output logic             ExMem_Zero,
    output logic [WIDTH-1:0] ExMem_DataRt,
    output logic [4:0]       ExMem_AddrRdRt,
    output logic             Ex_Stall
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, stateNext;
    logic [4:0] cnt;
    logic [WIDTH-1:0] opB, aluRes, unitA, unitB, unitAcc, unitRes, res;
    logic isMul, isDiv, isMulti;
    assign opB = IdEx_AluSrc ? IdEx_Imm : IdEx_DataRt;
    assign isMul = IdEx_AluCtrl == 4'b1000;
`ifdef EX_DIV_EN
    logic unitDiv;
    logic [WIDTH:0] remShift, remSub;
    assign isDiv = IdEx_AluCtrl == 4'b1010;
    assign remShift = {unitAcc, unitA[WIDTH-1]};
    assign remSub = remShift - {1'b0, unitB};
    assign unitRes = unitDiv ? unitA : unitAcc;
`else
    assign isDiv = 1'b0;
    assign unitRes = unitAcc;
`endif
    assign isMulti = isMul | isDiv;
    assign Ex_Stall = (state == IDLE && isMulti) || state == BUSY;
    always_comb begin
        aluRes = '0;
        case (IdEx_AluCtrl)
            4'b0000: aluRes = IdEx_DataRs & opB;
            4'b0001: aluRes = IdEx_DataRs | opB;
            4'b0010: aluRes = IdEx_DataRs + opB;
            4'b0110: aluRes = IdEx_DataRs - opB;
            4'b1100: aluRes = ~(IdEx_DataRs | opB);
            4'b0111: aluRes = {{(WIDTH-1){1'b0}}, $signed(IdEx_DataRs) < $signed(opB)};
            default: aluRes = '0;
        endcase
    end
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = isMulti ? BUSY : IDLE;
            BUSY: stateNext = cnt == 5'd31 ? DONE : BUSY;
            default: stateNext = IDLE;
        endcase
    end
    assign res = state == DONE ? unitRes : aluRes;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            unitA <= '0;
            unitB <= '0;
            unitAcc <= '0;
`ifdef EX_DIV_EN
            unitDiv <= 1'b0;
`endif
        end else begin
            state <= stateNext;
            if (state == IDLE) begin
                cnt <= '0;
                unitA <= IdEx_DataRs;
                unitB <= opB;
                unitAcc <= '0;
`ifdef EX_DIV_EN
                unitDiv <= isDiv;
`endif
            end else if (state == BUSY) begin
                cnt <= cnt + 5'd1;
`ifdef EX_DIV_EN
                if (unitDiv) begin
                    unitAcc <= remSub[WIDTH] ? remShift[WIDTH-1:0] : remSub[WIDTH-1:0];
                    unitA <= {unitA[WIDTH-2:0], ~remSub[WIDTH]};
                end else begin
`else
                begin
`endif
                    // shift-add: multiplicand moves left, multiplier bits consumed from the right
                    unitAcc <= unitAcc + (unitB[0] ? unitA : '0);
                    unitA <= unitA << 1;
                    unitB <= unitB >> 1;
                end
            end
        end
    end
    // a bubble is identical to the reset image, so both share one branch
    always_ff @(posedge CLK) begin
        if (RST || Ex_Stall) begin
            {ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite} <= '0;
            ExMem_AluOut <= '0;
            ExMem_Zero <= 1'b1;
            ExMem_DataRt <= '0;
            ExMem_AddrRdRt <= '0;
        end else begin
            {ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite} <=
                {IdEx_Jump, IdEx_Branch, IdEx_MemRead, IdEx_MemtoReg, IdEx_MemWrite, IdEx_RegWrite};
            ExMem_AluOut <= res;
            ExMem_Zero <= res == '0;
            ExMem_DataRt <= IdEx_DataRt;
            ExMem_AddrRdRt <= IdEx_AddrRdRt;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;
    logic CLK = 0, RST = 1;
    logic IdEx_Jump, IdEx_Branch, IdEx_MemRead, IdEx_MemtoReg, IdEx_MemWrite, IdEx_RegWrite;
    logic [3:0] IdEx_AluCtrl;
    logic IdEx_AluSrc;
    logic [31:0] IdEx_DataRs, IdEx_DataRt, IdEx_Imm;
    logic [4:0] IdEx_AddrRdRt;
    logic ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite;
    logic [31:0] ExMem_AluOut, ExMem_DataRt;
    logic ExMem_Zero, Ex_Stall;
    logic [4:0] ExMem_AddrRdRt;
    int checks = 0, failures = 0;

    ex_stage #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .IdEx_Jump(IdEx_Jump), .IdEx_Branch(IdEx_Branch), .IdEx_MemRead(IdEx_MemRead),
        .IdEx_MemtoReg(IdEx_MemtoReg), .IdEx_MemWrite(IdEx_MemWrite), .IdEx_RegWrite(IdEx_RegWrite),
        .IdEx_AluCtrl(IdEx_AluCtrl), .IdEx_AluSrc(IdEx_AluSrc), .IdEx_DataRs(IdEx_DataRs),
        .IdEx_DataRt(IdEx_DataRt), .IdEx_Imm(IdEx_Imm), .IdEx_AddrRdRt(IdEx_AddrRdRt),
        .ExMem_Jump(ExMem_Jump), .ExMem_Branch(ExMem_Branch), .ExMem_MemRead(ExMem_MemRead),
        .ExMem_MemtoReg(ExMem_MemtoReg), .ExMem_MemWrite(ExMem_MemWrite), .ExMem_RegWrite(ExMem_RegWrite),
        .ExMem_AluOut(ExMem_AluOut), .ExMem_Zero(ExMem_Zero), .ExMem_DataRt(ExMem_DataRt),
        .ExMem_AddrRdRt(ExMem_AddrRdRt), .Ex_Stall(Ex_Stall)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] exMemNow();
        return {ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite,
                ExMem_AluOut, ExMem_Zero, ExMem_DataRt, ExMem_AddrRdRt};
    endfunction

    function automatic logic [79:0] expPack(input logic [5:0] ctl, input logic [31:0] r,
                                            input logic [31:0] rt, input logic [4:0] rd);
        return {4'b0, ctl, r, r == 0, rt, rd};
    endfunction

    function automatic bit divEn();
`ifdef EX_DIV_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd6: return a - b;
            4'd12: return ~(a | b);
            4'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd8: return a * b;
            4'd10: return !divEn() ? 32'd0 : (b == 0 ? 32'hFFFF_FFFF : a / b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src, input logic [5:0] ctl, input logic [4:0] rd);
        {IdEx_Jump, IdEx_Branch, IdEx_MemRead, IdEx_MemtoReg, IdEx_MemWrite, IdEx_RegWrite} = ctl;
        IdEx_AluCtrl = op;
        IdEx_DataRs = a;
        IdEx_DataRt = rt;
        IdEx_Imm = imm;
        IdEx_AluSrc = src;
        IdEx_AddrRdRt = rd;
    endtask

    // the bench plays the hazard unit: inputs stay put while the stage stalls
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src, input logic [5:0] ctl, input logic [4:0] rd);
        logic [31:0] exp;
        bit multi;
        exp = refModel(op, a, src ? imm : rt);
        multi = op == 4'd8 || (divEn() && op == 4'd10);
        drive(op, a, rt, imm, src, ctl, rd);
        #1 checkVal({tag, "_stallIssue"}, 80'(Ex_Stall), 80'(multi));
        if (multi) begin
            for (int i = 0; i < 33; i++) begin
                if (i > 0) checkVal({tag, "_stallBusy"}, 80'(Ex_Stall), 80'd1);
                @(posedge CLK) #1;
                checkVal({tag, "_bubble"}, exMemNow(), expPack(6'd0, 32'd0, 32'd0, 5'd0));
            end
            checkVal({tag, "_stallDone"}, 80'(Ex_Stall), 80'd0);
        end
        @(posedge CLK) #1;
        checkVal({tag, "_aluOut"}, 80'(ExMem_AluOut), 80'(exp));
        checkVal({tag, "_exMem"}, exMemNow(), expPack(ctl, exp, rt, rd));
    endtask

    initial begin
        logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd7, 4'd8, 4'd10};
        logic [3:0] op;
        logic [31:0] a, b;
        drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 5'd0);
        @(posedge CLK) #1;
        checkVal("rst_stall", 80'(Ex_Stall), 80'd0);
        checkVal("rst_exMem", exMemNow(), expPack(6'd0, 32'd0, 32'd0, 5'd0));
        @(posedge CLK) #1;
        RST = 0;
        issue("add", 4'd2, 32'h7FFF_FFFF, 32'd1, 32'h1234, 1'b0, 6'b101011, 5'd3);
        issue("sltA", 4'd7, 32'hFFFF_FFFF, 32'h55, 32'd1, 1'b1, 6'b000001, 5'd4);
        issue("sltB", 4'd7, 32'd1, 32'h55, 32'hFFFF_FFFF, 1'b1, 6'b000001, 5'd5);
        issue("mul", 4'd8, 32'h0001_2345, 32'h100, 32'd0, 1'b0, 6'b000001, 5'd6);
        issue("sub", 4'd6, 32'd9, 32'd9, 32'd0, 1'b0, 6'b000001, 5'd7);
        issue("mulB2B1", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 6'b010001, 5'd8);
        issue("mulB2B2", 4'd8, 32'h8000_0001, 32'd3, 32'd0, 1'b0, 6'b000011, 5'd9);
        issue("div", 4'd10, 32'd100, 32'd7, 32'd0, 1'b0, 6'b000001, 5'd10);
        issue("div0", 4'd10, 32'd5, 32'd0, 32'd0, 1'b0, 6'b000001, 5'd11);
        issue("undef", 4'd15, 32'hABCD, 32'h1234, 32'd0, 1'b0, 6'b111111, 5'd12);
        // abort a MUL in its tenth cycle; the product must never surface
        drive(4'd8, 32'h0001_2345, 32'h100, 32'd0, 1'b0, 6'b000001, 5'd6);
        repeat (10) @(posedge CLK);
        #1 RST = 1;
        drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 5'd0);
        @(posedge CLK) #1;
        RST = 0;
        #1 checkVal("abort_stall", 80'(Ex_Stall), 80'd0);
        checkVal("abort_exMem", exMemNow(), expPack(6'd0, 32'd0, 32'd0, 5'd0));
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK) #1;
            checkVal("abort_noResult", exMemNow(), expPack(6'd0, 32'd0, 32'd0, 5'd0));
        end
        for (int n = 0; n < 60; n++) begin
            op = (n % 9 == 8) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 7)];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (n % 11 == 5) b = a;
            issue("rand", op, a, b, $urandom, 1'($urandom), 6'($urandom), 5'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
